// File: rtl/run_controller.sv
// run_controller
//
// Host-side sequencer for a processor's init/restart/done control interface.
// Launches a cold run (proc_init held for INIT_CYCLES) or a warm run (one-cycle
// proc_restart), counts RUN cycles until proc_done or TIMEOUT, then holds the
// result behind a valid/ack handshake.
//
// Ports:
//   clock_i          system clock, rising edge
//   init_i           synchronous active-high reset
//   start_i          run request, sampled only in IDLE
//   cold_i           with start_i: 1 = cold start, 0 = warm start
//   proc_done_i      done from the processor (only honoured in RUN)
//   result_ack_i     consumer accepts the result
//   busy_o           high in every state except IDLE
//   proc_init_o      init to the processor
//   proc_restart_o   restart to the processor
//   result_valid_o   result fields valid
//   cycle_count_o    RUN cycles counted before done or timeout
//   timed_out_o      last run aborted on timeout
//   run_count_o      completed (non-timeout) runs, wraps 255 -> 0
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for start; result fields keep their last values
// S_INIT    | proc_init held high, INIT_CYCLES cycles in total
// S_RESTART | proc_restart high for one cycle
// S_RUN     | counting cycles until proc_done or TIMEOUT
// S_REPORT  | result_valid high, waiting for result_ack

module run_controller #(
    parameter int unsigned INIT_CYCLES = 2,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter int unsigned TIMEOUT     = 1000
) (
    input  logic                 clock_i,
    input  logic                 init_i,
    input  logic                 start_i,
    input  logic                 cold_i,
    input  logic                 proc_done_i,
    input  logic                 result_ack_i,
    output logic                 busy_o,
    output logic                 proc_init_o,
    output logic                 proc_restart_o,
    output logic                 result_valid_o,
    output logic [CNT_WIDTH-1:0] cycle_count_o,
    output logic                 timed_out_o,
    output logic [7:0]           run_count_o
);

    localparam int unsigned IW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
    localparam logic [IW-1:0]        INIT_LAST = IW'(INIT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_C = CNT_WIDTH'(TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_RESTART,
        S_RUN,
        S_REPORT
    } state_e;

    state_e               state_q, state_d;
    logic [IW-1:0]        init_cnt_q, init_cnt_d;
    logic [CNT_WIDTH-1:0] run_cnt_q, run_cnt_d;
    logic                 proc_init_q, proc_init_d;
    logic                 proc_restart_q, proc_restart_d;
    logic                 busy_q, busy_d;
    logic                 result_valid_q, result_valid_d;
    logic [CNT_WIDTH-1:0] cycle_count_q, cycle_count_d;
    logic                 timed_out_q, timed_out_d;
    logic [7:0]           run_count_q, run_count_d;

    always_comb begin
        state_d        = state_q;
        init_cnt_d     = init_cnt_q;
        run_cnt_d      = run_cnt_q;
        proc_init_d    = proc_init_q;
        proc_restart_d = 1'b0;
        cycle_count_d  = cycle_count_q;
        timed_out_d    = timed_out_q;
        run_count_d    = run_count_q;

        case (state_q)
            S_IDLE: begin
                // Releases the processor from the init held during reset.
                proc_init_d = 1'b0;
                if (start_i) begin
                    if (cold_i) begin
                        state_d     = S_INIT;
                        proc_init_d = 1'b1;
                        init_cnt_d  = INIT_LAST;
                    end else begin
                        state_d        = S_RESTART;
                        proc_restart_d = 1'b1;
                    end
                end
            end
            S_INIT: begin
                if (init_cnt_q == '0) begin
                    proc_init_d = 1'b0;
                    run_cnt_d   = '0;
                    state_d     = S_RUN;
                end else begin
                    init_cnt_d = init_cnt_q - IW'(1);
                end
            end
            S_RESTART: begin
                run_cnt_d = '0;
                state_d   = S_RUN;
            end
            S_RUN: begin
                // Done is checked first so a done coinciding with the
                // timeout count still counts as a success.
                if (proc_done_i) begin
                    cycle_count_d = run_cnt_q;
                    timed_out_d   = 1'b0;
                    run_count_d   = run_count_q + 8'd1;
                    state_d       = S_REPORT;
                end else if (run_cnt_q == TIMEOUT_C) begin
                    cycle_count_d = TIMEOUT_C;
                    timed_out_d   = 1'b1;
                    state_d       = S_REPORT;
                end else begin
                    run_cnt_d = run_cnt_q + CNT_WIDTH'(1);
                end
            end
            S_REPORT: begin
                if (result_ack_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d         = (state_d != S_IDLE);
        result_valid_d = (state_d == S_REPORT);
    end

    always_ff @(posedge clock_i) begin
        if (init_i) begin
            state_q        <= S_IDLE;
            init_cnt_q     <= '0;
            run_cnt_q      <= '0;
            proc_init_q    <= 1'b1;
            proc_restart_q <= 1'b0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            cycle_count_q  <= '0;
            timed_out_q    <= 1'b0;
            run_count_q    <= 8'd0;
        end else begin
            state_q        <= state_d;
            init_cnt_q     <= init_cnt_d;
            run_cnt_q      <= run_cnt_d;
            proc_init_q    <= proc_init_d;
            proc_restart_q <= proc_restart_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            cycle_count_q  <= cycle_count_d;
            timed_out_q    <= timed_out_d;
            run_count_q    <= run_count_d;
        end
    end

    assign busy_o         = busy_q;
    assign proc_init_o    = proc_init_q;
    assign proc_restart_o = proc_restart_q;
    assign result_valid_o = result_valid_q;
    assign cycle_count_o  = cycle_count_q;
    assign timed_out_o    = timed_out_q;
    assign run_count_o    = run_count_q;

endmodule

// File: tb/tb_run_controller.sv
// Directed bench for run_controller with INIT_CYCLES=2, TIMEOUT=10.
// Inputs change and outputs are sampled 1 time unit after each rising edge.

module tb_run_controller;

    logic        clk = 1'b0;
    logic        init, start, cold, done, ack;
    logic        busy, p_init, p_restart, rvalid, tout;
    logic [15:0] ccount;
    logic [7:0]  rcount;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    run_controller #(
        .INIT_CYCLES(2),
        .CNT_WIDTH  (16),
        .TIMEOUT    (10)
    ) dut (
        .clock_i       (clk),
        .init_i        (init),
        .start_i       (start),
        .cold_i        (cold),
        .proc_done_i   (done),
        .result_ack_i  (ack),
        .busy_o        (busy),
        .proc_init_o   (p_init),
        .proc_restart_o(p_restart),
        .result_valid_o(rvalid),
        .cycle_count_o (ccount),
        .timed_out_o   (tout),
        .run_count_o   (rcount)
    );

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue a cold start from IDLE, check the 2-cycle proc_init window,
    // and leave the DUT on the first cycle of RUN (counter = 0).
    task automatic cold_start(input string tag);
        start = 1'b1; cold = 1'b1;
        tick();
        chk({tag, "_init1"}, p_init, 1);
        chk({tag, "_busy"},  busy, 1);
        start = 1'b1;            // start during INIT must be ignored
        tick();
        chk({tag, "_init2"}, p_init, 1);
        start = 1'b0;
        tick();
        chk({tag, "_init_off"}, p_init, 0);
    endtask

    initial begin
        init = 1'b1; start = 1'b0; cold = 1'b0; done = 1'b0; ack = 1'b0;

        // Reset for two cycles
        tick(2);
        chk("rst_pinit",  p_init, 1);
        chk("rst_prest",  p_restart, 0);
        chk("rst_busy",   busy, 0);
        chk("rst_valid",  rvalid, 0);
        chk("rst_tout",   tout, 0);
        chk("rst_ccount", ccount, 0);
        chk("rst_rcount", rcount, 0);
        init = 1'b0;
        tick();
        chk("rel_pinit", p_init, 0);

        // Cold run, done 5 cycles into RUN, start pulse mid-RUN
        cold_start("c1");
        tick(2);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick(2);
        chk("c1_novalid", rvalid, 0);
        done = 1'b1;
        tick();
        chk("c1_valid",  rvalid, 1);
        chk("c1_ccount", ccount, 5);
        chk("c1_tout",   tout, 0);
        chk("c1_rcount", rcount, 1);

        // Hold ack low 4 cycles with a start pulse in REPORT
        start = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("hold_valid",  rvalid, 1);
            chk("hold_ccount", ccount, 5);
            chk("hold_tout",   tout, 0);
            chk("hold_rcount", rcount, 1);
        end
        ack = 1'b1;              // start coincides with ack: ignored
        tick();
        chk("ack_valid", rvalid, 0);
        chk("ack_busy",  busy, 0);
        start = 1'b0; ack = 1'b0;
        tick();
        chk("idle_busy",   busy, 0);
        chk("idle_ccount", ccount, 5);

        // Warm start with stale done still high
        start = 1'b1; cold = 1'b0;
        tick();
        chk("w_prest1", p_restart, 1);
        chk("w_pinit",  p_init, 0);
        chk("w_busy",   busy, 1);
        start = 1'b0;
        tick();
        chk("w_prest0", p_restart, 0);
        chk("w_stale",  rvalid, 0);
        done = 1'b0;
        tick(3);
        chk("w_novalid", rvalid, 0);
        done = 1'b1;
        tick();
        chk("w_valid",  rvalid, 1);
        chk("w_ccount", ccount, 3);
        chk("w_tout",   tout, 0);
        chk("w_rcount", rcount, 2);
        ack = 1'b1;
        tick();
        ack = 1'b0; done = 1'b0;

        // Timeout: done never asserted
        cold_start("t1");
        tick(10);
        chk("t1_novalid", rvalid, 0);
        tick();
        chk("t1_valid",  rvalid, 1);
        chk("t1_tout",   tout, 1);
        chk("t1_ccount", ccount, 10);
        chk("t1_rcount", rcount, 2);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("t1_idle_tout", tout, 1);

        // Done exactly at counter = TIMEOUT wins
        cold_start("t2");
        tick(10);
        chk("t2_novalid", rvalid, 0);
        done = 1'b1;
        tick();
        chk("t2_valid",  rvalid, 1);
        chk("t2_tout",   tout, 0);
        chk("t2_ccount", ccount, 10);
        chk("t2_rcount", rcount, 3);
        ack = 1'b1;
        tick();
        ack = 1'b0; done = 1'b0;

        // Reset mid-RUN at counter = 3
        cold_start("m1");
        tick(3);
        init = 1'b1;
        tick();
        chk("mr_pinit",  p_init, 1);
        chk("mr_busy",   busy, 0);
        chk("mr_valid",  rvalid, 0);
        chk("mr_rcount", rcount, 0);
        chk("mr_ccount", ccount, 0);
        init = 1'b0;
        tick();
        chk("mr_rel_pinit", p_init, 0);
        tick(2);
        chk("mr_novalid", rvalid, 0);

        // Next cold run reports normally
        cold_start("m2");
        tick(5);
        done = 1'b1;
        tick();
        chk("m2_valid",  rvalid, 1);
        chk("m2_ccount", ccount, 5);
        chk("m2_tout",   tout, 0);
        chk("m2_rcount", rcount, 1);
        ack = 1'b1;
        tick();
        ack = 1'b0; done = 1'b0;
        chk("m2_idle", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
